// File: rtl/ff_stuffer_if.sv
// Handshake bundle between the Huffman encoder, the 0xFF stuffer and the output sink.
interface ff_stuffer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [2:0]  in_bytes;
  logic        in_done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [2:0]  out_bytes;

  // Encoder/sink side: drives the input word and the sink's ready.
  modport master (
    output in_data, in_valid, in_last, in_bytes, out_ready,
    input  in_done, out_data, out_valid, out_last, out_bytes
  );

  // Stuffer side.
  modport slave (
    input  in_data, in_valid, in_last, in_bytes, out_ready,
    output in_done, out_data, out_valid, out_last, out_bytes
  );
endinterface

// File: rtl/ff_stuffer.sv
// JPEG byte stuffer: walks each 32-bit Huffman word MSB-first, inserts a 0x00
// after every 0xFF and repacks the result into 32-bit output words.
module ff_stuffer (
  input  logic           clk,
  input  logic           rst,
  ff_stuffer_if.slave    bus,
  output logic           busy,
  output logic [15:0]    stuff_cnt
);

  typedef enum logic [2:0] {IDLE, BYTE, STUFF, FLUSH, DONE} state_t;

  state_t          state_q, state_d;
  logic [0:3][7:0] word_q, word_d;   // captured input word, [0] = MSB byte
  logic [0:3][7:0] asm_q, asm_d;     // output assembler, [0] = bits [31:24]
  logic [2:0]      nb_q, nb_d;       // valid bytes in captured word (1..4)
  logic            last_q, last_d;
  logic [1:0]      idx_q, idx_d;     // next input byte to emit
  logic [2:0]      cnt_q, cnt_d;     // bytes held in the assembler (0..4)
  logic [15:0]     stuff_q, stuff_d;

  logic       hs;
  logic       can_wr;
  logic       at_end;
  logic       adv;
  logic [7:0] cur_byte;

  // Output view is a pure function of the registered state.
  assign bus.out_valid = (cnt_q == 3'd4) || (state_q == FLUSH);
  assign bus.out_last  = (state_q == FLUSH);
  assign bus.out_bytes = cnt_q;
  assign bus.out_data  = asm_q;
  assign bus.in_done   = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign stuff_cnt     = stuff_q;

  assign hs       = bus.out_valid && bus.out_ready;
  // A full assembler blocks writes; this also keeps writes out of handshake cycles.
  assign can_wr   = (cnt_q < 3'd4);
  assign at_end   = ({1'b0, idx_q} == (nb_q - 3'd1));
  assign cur_byte = word_q[idx_q];

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      asm_q   <= '0;
      nb_q    <= 3'd0;
      last_q  <= 1'b0;
      idx_q   <= 2'd0;
      cnt_q   <= 3'd0;
      stuff_q <= 16'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      asm_q   <= asm_d;
      nb_q    <= nb_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stuff_q <= stuff_d;
    end
  end

  // Next-state: byte walk, stuffing, draining and the done pulse.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    asm_d   = asm_q;
    nb_d    = nb_q;
    last_d  = last_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stuff_d = stuff_q;
    adv     = 1'b0;

    // Sink took the word: empty the assembler (never coincides with a write).
    if (hs) begin
      cnt_d = 3'd0;
      asm_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          last_d  = bus.in_last;
          // Out-of-range byte counts fall back to a full word.
          nb_d    = (bus.in_last && bus.in_bytes != 3'd0 && bus.in_bytes <= 3'd4)
                    ? bus.in_bytes : 3'd4;
          idx_d   = 2'd0;
          state_d = BYTE;
        end
      end
      BYTE: begin
        if (can_wr) begin
          asm_d[cnt_q[1:0]] = cur_byte;
          cnt_d = cnt_q + 3'd1;
          if (cur_byte == 8'hFF) state_d = STUFF;
          else                   adv     = 1'b1;
        end
      end
      STUFF: begin
        if (can_wr) begin
          asm_d[cnt_q[1:0]] = 8'h00;
          cnt_d = cnt_q + 3'd1;
          if (stuff_q != 16'hFFFF) stuff_d = stuff_q + 16'd1;
          adv = 1'b1;
        end
      end
      FLUSH: begin
        if (hs) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Move to the next input byte, or finish the word.
    if (adv) begin
      if (at_end) begin
        state_d = last_q ? FLUSH : DONE;
      end else begin
        idx_d   = idx_q + 2'd1;
        state_d = BYTE;
      end
    end
  end

endmodule

// File: tb/tb_ff_stuffer.sv
// Self-checking bench for ff_stuffer: byte-stream reference model feeding a
// scoreboard of expected output words, plus directed latency/backpressure/reset checks.
module tb_ff_stuffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] stuff_cnt;

  ff_stuffer_if bus();

  ff_stuffer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .stuff_cnt (stuff_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected output words: {data, last, bytes}.
  logic [35:0]     exp_q[$];
  logic [0:3][7:0] m_acc;
  int              m_n;
  int              m_stuff;
  bit              rnd_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_acc   = '0;
    m_n     = 0;
    m_stuff = 0;
  endfunction

  function automatic void m_emit(bit last);
    exp_q.push_back({m_acc, last, 3'(m_n)});
    m_acc = '0;
    m_n   = 0;
  endfunction

  // Append one byte; a full assembler goes out as a non-last word unless this
  // byte is the very last of the frame (then it leaves as the flush word).
  function automatic void m_put(logic [7:0] b, bit final_b);
    m_acc[m_n] = b;
    m_n++;
    if (m_n == 4 && !final_b) m_emit(1'b0);
  endfunction

  function automatic void m_word(logic [31:0] d, bit last, logic [2:0] bytes);
    int         nb;
    logic [7:0] b;
    nb = last ? int'(bytes) : 4;
    for (int i = 0; i < nb; i++) begin
      b = d[31-8*i -: 8];
      m_put(b, last && (i == nb-1) && (b != 8'hFF));
      if (b == 8'hFF) begin
        m_stuff++;
        m_put(8'h00, last && (i == nb-1));
      end
    end
    if (last) m_emit(1'b1);
  endfunction

  // Present a word to the DUT (caller is at a negedge).
  task automatic drive(input logic [31:0] d, input bit last, input logic [2:0] bytes, input bit model);
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = bytes;
    bus.in_valid = 1'b1;
    if (model) m_word(d, last, bytes);
  endtask

  // Wait for in_done (bounded); n = negedges waited.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_done && n < 300);
    if (!bus.in_done) chk("done_timeout", bus.in_done, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic set_ready(input bit r);
    @(posedge clk);
    #1 bus.out_ready = r;
  endtask

  // Scoreboard: pop and compare every accepted output word.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0)
        chk("extra_word", {bus.out_data, bus.out_last, bus.out_bytes}, 0);
      else
        chk("out_word", {bus.out_data, bus.out_last, bus.out_bytes}, exp_q.pop_front());
    end
  end

  // Random sink backpressure, changed just after the active edge.
  always @(posedge clk) begin
    if (rnd_ready) #1 bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int         n;
    int         dn;
    logic [31:0] d;
    bit          lst;
    logic [2:0]  nb;

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = 3'd0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    m_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_ctl",   {bus.in_done, bus.out_valid, bus.out_last, busy}, 0);
    chk("rst_data",  {bus.out_data, bus.out_bytes}, 0);
    chk("rst_stuff", stuff_cnt, 0);
    rst = 1'b0;

    // Plain word: in_done and out_valid five cycles after capture.
    drive(32'h12345678, 1'b0, 3'd0, 1'b1);
    wait_done(n);
    chk("lat_cycles", n, 5);
    chk("lat_valid",  bus.out_valid, 1);
    chk("lat_data",   bus.out_data, 32'h12345678);
    chk("lat_stuff",  stuff_cnt, 0);

    // Stuffed bytes spilling across word boundaries.
    drive(32'hFF00FF11, 1'b0, 3'd0, 1'b1);
    wait_done(n);
    drive(32'hAABBCCDD, 1'b1, 3'd4, 1'b1);
    wait_done(n);
    chk("spill_stuff", stuff_cnt, 2);

    // All-0xFF last word: two full stuffed words, second one last.
    drive(32'hFFFFFFFF, 1'b1, 3'd4, 1'b1);
    wait_done(n);
    chk("allff_stuff", stuff_cnt, 6);

    // Short last word held by the sink: in_done only after handshake.
    set_ready(1'b0);
    @(negedge clk);
    drive(32'hABCD0000, 1'b1, 3'd2, 1'b1);
    dn = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.in_done) dn++;
    end
    chk("short_nodone", dn, 0);
    chk("short_out", {bus.out_valid, bus.out_last, bus.out_bytes}, {1'b1, 1'b1, 3'd2});
    chk("short_data", bus.out_data, 32'hABCD0000);
    set_ready(1'b1);
    wait_done(n);

    // Full assembler mid-word under backpressure: output frozen, no bytes lost.
    set_ready(1'b0);
    @(negedge clk);
    drive(32'h11FF2233, 1'b0, 3'd0, 1'b1);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.in_done) dn++;
    end
    chk("bp_data_a", bus.out_data, 32'h11FF0022);
    repeat (10) begin
      @(negedge clk);
      if (bus.in_done) dn++;
    end
    chk("bp_data_b", bus.out_data, 32'h11FF0022);
    chk("bp_nodone", dn, 0);
    set_ready(1'b1);
    wait_done(n);
    drive(32'h44556677, 1'b1, 3'd4, 1'b1);
    wait_done(n);
    chk("bp_drained", exp_q.size(), 0);

    // Reset in the middle of a word discards it.
    @(negedge clk);
    drive(32'hFFFFFFFF, 1'b0, 3'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("mid_rst_ctl",  {bus.in_done, bus.out_valid, bus.out_last, busy}, 0);
    chk("mid_rst_data", {bus.out_data, bus.out_bytes, stuff_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    drive(32'hFF123456, 1'b1, 3'd4, 1'b1);
    wait_done(n);
    chk("post_rst_stuff", stuff_cnt, 1);

    // Random words and random backpressure.
    rnd_ready = 1'b1;
    for (int w = 0; w < 30; w++) begin
      d = '0;
      for (int j = 0; j < 4; j++)
        d = {d[23:0], (($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom))};
      lst = (w == 29) || ($urandom_range(0, 3) == 0);
      nb  = 3'($urandom_range(1, 4));
      @(negedge clk);
      drive(d, lst, nb, 1'b1);
      wait_done(n);
    end
    rnd_ready = 1'b0;
    set_ready(1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_stuff", stuff_cnt, m_stuff);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
